// File: rtl/int_to_fp32_norm.sv
// int_to_fp32_norm: 3-stage pipelined 32-bit integer to IEEE-754 single converter, RNE rounding
// ports: clk, rst (sync, active-high);
//        input side  i_valid/i_ready/i_data/i_tag;
//        output side o_valid/o_ready/o_data/o_tag/o_inexact (o_inexact = rounding dropped non-zero bits)
module int_to_fp32_norm #(
   parameter bit SIGNED     = 1'b1,
   parameter int TAG_WIDTH  = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_valid,
   output logic                  i_ready,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic [TAG_WIDTH-1:0]  i_tag,
   output logic                  o_valid,
   input  logic                  o_ready,
   output logic [31:0]           o_data,
   output logic [TAG_WIDTH-1:0]  o_tag,
   output logic                  o_inexact
);
   if (DATA_WIDTH != 32) begin : g_width_check
      $error("int_to_fp32_norm supports DATA_WIDTH = 32 only");
   end

   logic                 stall;
   logic                 in_sign;
   logic [31:0]          in_mag;
   logic                 s1_valid, s1_sign, s1_zero;
   logic [31:0]          s1_mag;
   logic [TAG_WIDTH-1:0] s1_tag;
   logic [4:0]           lzc;
   logic                 s2_valid, s2_sign, s2_zero;
   logic [30:0]          s2_frac;
   logic [7:0]           s2_exp;
   logic [TAG_WIDTH-1:0] s2_tag;
   logic [22:0]          mant;
   logic                 guard, sticky, round_up;
   logic [23:0]          mant_sum;
   logic [7:0]           exp_out;

   assign stall   = o_valid & ~o_ready;
   assign i_ready = ~stall;
   assign in_sign = SIGNED & i_data[31];
   // -2^31 negates to itself, which read as unsigned is the correct magnitude 0x80000000
   assign in_mag  = in_sign ? -i_data : i_data;

   // highest set bit wins, giving lzc = 31 - msb index; value for a zero magnitude is unused
   always_comb begin
      lzc = 5'd0;
      for (int i = 0; i < 32; i++) lzc = s1_mag[i] ? 5'(31 - i) : lzc;
   end

   // the normalised bit 31 is the implicit one, so only bits 30:0 are kept
   assign mant     = s2_frac[30:8];
   assign guard    = s2_frac[7];
   assign sticky   = |s2_frac[6:0];
   assign round_up = guard & (sticky | mant[0]);
   assign mant_sum = {1'b0, mant} + 24'(round_up);
   // a carry out leaves mant_sum[22:0] all zero, so only the exponent needs bumping
   assign exp_out  = s2_exp + 8'(mant_sum[23]);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         o_valid   <= 1'b0;
         o_data    <= 32'd0;
         o_tag     <= '0;
         o_inexact <= 1'b0;
      end else if (!stall) begin
         s1_valid <= i_valid;
         s2_valid <= s1_valid;
         o_valid  <= s2_valid;
         if (i_valid) begin
            s1_sign <= in_sign;
            s1_mag  <= in_mag;
            s1_zero <= (i_data == '0);
            s1_tag  <= i_tag;
         end
         if (s1_valid) begin
            s2_sign <= s1_sign;
            s2_zero <= s1_zero;
            s2_frac <= 31'(s1_mag << lzc);
            s2_exp  <= 8'd158 - 8'(lzc);
            s2_tag  <= s1_tag;
         end
         if (s2_valid) begin
            o_data    <= s2_zero ? 32'd0 : {s2_sign, exp_out, mant_sum[22:0]};
            o_tag     <= s2_tag;
            o_inexact <= ~s2_zero & (guard | sticky);
         end
      end
   end
endmodule

// File: tb/tb_int_to_fp32_norm.sv
// tb_int_to_fp32_norm: scoreboard bench running a signed and an unsigned converter side by side
// ports: none
module tb_int_to_fp32_norm;
   logic        clk = 1'b0, rst = 1'b1, i_valid = 1'b0, o_ready = 1'b1;
   logic [31:0] i_data = 32'd0;
   logic [3:0]  i_tag = 4'd0;
   logic        i_ready_s, i_ready_u, o_valid_s, o_valid_u, o_inx_s, o_inx_u;
   logic [31:0] o_data_s, o_data_u;
   logic [3:0]  o_tag_s, o_tag_u;

   typedef struct {
      logic [31:0] ds;
      logic        is;
      logic [31:0] du;
      logic        iu;
      logic [3:0]  tag;
   } exp_t;

   exp_t        q[$];
   int          errors = 0, checks = 0, cyc = 0;
   bit          rnd = 1'b0;
   logic [31:0] bp_vals [8];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   int_to_fp32_norm #(.SIGNED(1'b1), .TAG_WIDTH(4), .DATA_WIDTH(32)) u_s (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready_s), .i_data(i_data), .i_tag(i_tag),
      .o_valid(o_valid_s), .o_ready(o_ready), .o_data(o_data_s), .o_tag(o_tag_s), .o_inexact(o_inx_s));

   int_to_fp32_norm #(.SIGNED(1'b0), .TAG_WIDTH(4), .DATA_WIDTH(32)) u_u (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready_u), .i_data(i_data), .i_tag(i_tag),
      .o_valid(o_valid_u), .o_ready(o_ready), .o_data(o_data_u), .o_tag(o_tag_u), .o_inexact(o_inx_u));

   // reference: returns {inexact, fp32 bits}
   function automatic logic [32:0] ref_fp(input logic [31:0] d, input bit sgn);
      logic        s;
      logic [31:0] m;
      logic [63:0] qt, rem, half;
      logic        up;
      int          e, sh;
      s = sgn & d[31];
      m = s ? (~d + 32'd1) : d;
      if (m == 32'd0) return 33'd0;
      e = 31;
      while (!m[e]) e--;
      if (e <= 23) return {1'b0, s, 8'(127 + e), 23'(64'(m) << (23 - e))};
      sh   = e - 23;
      qt   = 64'(m) >> sh;
      rem  = 64'(m) - (qt << sh);
      half = 64'd1 << (sh - 1);
      up   = (rem > half) || (rem == half && qt[0]);
      qt   = qt + 64'(up);
      if (qt[24]) begin
         qt = qt >> 1;
         e++;
      end
      return {rem != 64'd0, s, 8'(127 + e), qt[22:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // scoreboard: push on input handshake, pop on output handshake
   always @(negedge clk) begin
      exp_t        e;
      logic [32:0] r_s, r_u;
      if (rst) q.delete();
      else begin
         if (o_valid_s && o_ready) begin
            if (q.size() == 0) chk("sb_unexpected_output", 64'd1, 64'd0);
            else begin
               e = q.pop_front();
               chk("sb_signed",   {o_data_s, o_inx_s, o_tag_s}, {e.ds, e.is, e.tag});
               chk("sb_unsigned", {o_valid_u, o_data_u, o_inx_u, o_tag_u}, {1'b1, e.du, e.iu, e.tag});
            end
         end
         if (i_valid && i_ready_s) begin
            r_s = ref_fp(i_data, 1'b1);
            r_u = ref_fp(i_data, 1'b0);
            q.push_back('{ds: r_s[31:0], is: r_s[32], du: r_u[31:0], iu: r_u[32], tag: i_tag});
         end
      end
   end

   // called just after a rising edge; returns just after the edge that accepted the sample
   task automatic send(input logic [31:0] d, input logic [3:0] t);
      logic acc;
      acc = 1'b0;
      i_valid = 1'b1;
      i_data  = d;
      i_tag   = t;
      for (int n = 0; n < 200 && !acc; n++) begin
         @(negedge clk);
         acc = i_ready_s;
         @(posedge clk);
         #1;
         if (rnd) o_ready = ($urandom_range(0, 3) != 0);
      end
      chk("send_accepted", 64'(acc), 64'd1);
      i_valid = 1'b0;
   endtask

   task automatic directed(input logic [31:0] d, input logic [31:0] es, input logic is,
                           input logic [31:0] eu, input logic iu);
      send(d, 4'hA);
      chk("lat_not_yet", {o_valid_s, o_valid_u}, 2'b00);
      @(posedge clk); #1;
      chk("lat_not_yet", {o_valid_s, o_valid_u}, 2'b00);
      @(posedge clk); #1;
      chk("lat_3_valid", {o_valid_s, o_valid_u}, 2'b11);
      chk("dir_signed",   {o_data_s, o_inx_s}, {es, is});
      chk("dir_unsigned", {o_data_u, o_inx_u}, {eu, iu});
   endtask

   task automatic drain();
      o_ready = 1'b1;
      for (int n = 0; n < 60 && q.size() != 0; n++) begin
         @(posedge clk); #1;
      end
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   initial begin
      logic [32:0] r;
      logic [31:0] v;
      int          c0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_o_valid", {o_valid_s, o_valid_u}, 2'b00);
      chk("rst_o_data", {o_data_s, o_data_u}, 64'd0);
      chk("rst_tag_inexact", {o_tag_s, o_tag_u, o_inx_s, o_inx_u}, 10'd0);
      chk("rst_i_ready", {i_ready_s, i_ready_u}, 2'b11);

      directed(32'd1,        32'h3F800000, 1'b0, 32'h3F800000, 1'b0);
      directed(32'hFFFFFFFF, 32'hBF800000, 1'b0, 32'h4F800000, 1'b1);
      directed(32'd0,        32'h00000000, 1'b0, 32'h00000000, 1'b0);
      directed(32'h80000000, 32'hCF000000, 1'b0, 32'h4F000000, 1'b0);
      directed(32'd16777217, 32'h4B800000, 1'b1, 32'h4B800000, 1'b1);
      directed(32'd16777219, 32'h4B800002, 1'b1, 32'h4B800002, 1'b1);
      directed(32'h7FFFFFFF, 32'h4F000000, 1'b1, 32'h4F000000, 1'b1);
      drain();

      for (int k = 0; k < 8; k++) bp_vals[k] = $urandom;
      r = ref_fp(bp_vals[1], 1'b1);
      fork
         begin
            c0 = cyc;
            for (int k = 0; k < 8; k++) send(bp_vals[k], 4'(k));
            chk("bp_stream_cycles", 64'(cyc - c0), 64'd13);
         end
         begin
            repeat (4) @(posedge clk);
            #1 o_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               chk("bp_i_ready_low", {i_ready_s, i_ready_u}, 2'b00);
               chk("bp_hold", {o_valid_s, o_tag_s, o_data_s, o_inx_s}, {1'b1, 4'd1, r[31:0], r[32]});
            end
            @(posedge clk);
            #1 o_ready = 1'b1;
         end
      join
      drain();

      for (int k = 0; k < 3; k++) send(32'd100 + 32'(k), 4'(k));
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_o_valid", {o_valid_s, o_valid_u}, 2'b00);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk("midrst_no_stale", {o_valid_s, o_valid_u, i_ready_s, i_ready_u}, 4'b0011);
      end
      directed(32'd5, 32'h40A00000, 1'b0, 32'h40A00000, 1'b0);
      drain();

      rnd = 1'b1;
      for (int n = 0; n < 10000; n++) begin
         case (n % 4)
            0:       v = $urandom;
            1:       v = $urandom >> $urandom_range(0, 31);
            2:       v = ~($urandom >> $urandom_range(0, 31)) + 32'd1;
            default: v = (32'($urandom_range(1, 255)) << $urandom_range(0, 24)) + 32'($urandom_range(0, 2));
         endcase
         send(v, 4'($urandom));
      end
      rnd = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
